wrptr_level: RTL and testbench

// - Write-domain decoder for the read pointer of the async FIFO. It synchronizes the Gray-coded read

---
 rtl/wrptr_level_pkg.sv | 28 ++
 rtl/wrptr_level_if.sv | 29 ++
 rtl/wrptr_level_ptr_sync.sv | 32 +++
 rtl/wrptr_level.sv | 74 +++++++
 tb/tb_wrptr_level.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/wrptr_level_pkg.sv
// Shared types and pointer helpers for the write-domain read-pointer decoder.
// Also used by the read-domain side of the async FIFO.
package wrptr_level_pkg;

  localparam int ADDRSIZE_DEF    = 4;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int PTR_MAX_W       = 32;

  typedef struct packed {
    logic gray;
    logic ovf;
  } err_t;

  // Prefix-XOR from the MSB down; narrower pointers are zero-extended by the caller.
  function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
    logic [PTR_MAX_W-1:0] b;
    b = g;
    for (int i = 1; i < PTR_MAX_W; i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

  function automatic int unsigned popcount(input logic [PTR_MAX_W-1:0] v);
    return $countones(v);
  endfunction

endpackage

// File: rtl/wrptr_level_if.sv
// Pointer/status bundle between the write-side FIFO logic and the read-pointer decoder.
interface wrptr_level_if import wrptr_level_pkg::*; #(
  parameter int ADDRSIZE = ADDRSIZE_DEF
) ();

  localparam int PW = ADDRSIZE + 1;

  logic [PW-1:0] rptr;
  logic [PW-1:0] wbin;
  logic [PW-1:0] awfull_thresh;
  logic          err_clr;
  logic [PW-1:0] wq2_rptr;
  logic [PW-1:0] wrbin;
  logic [PW-1:0] wlevel;
  logic          awfull;
  logic          gray_err;
  logic          ovf_err;

  modport master (
    output rptr, wbin, awfull_thresh, err_clr,
    input  wq2_rptr, wrbin, wlevel, awfull, gray_err, ovf_err
  );

  modport slave (
    input  rptr, wbin, awfull_thresh, err_clr,
    output wq2_rptr, wrbin, wlevel, awfull, gray_err, ovf_err
  );

endinterface

// File: rtl/wrptr_level_ptr_sync.sv
// N-stage flop chain for carrying a Gray pointer across clock domains.
// Reused for both the wclk-side rptr and the rclk-side wptr synchronizers.
module ptr_sync #(
  parameter int WIDTH       = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [SYNC_STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: this array is a handful of flops, not a RAM, so every entry is reset.
      for (int i = 0; i < SYNC_STAGES; i++) begin
        stage[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking so each stage captures its neighbour's pre-edge value.
      stage[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign q = stage[SYNC_STAGES-1];

endmodule

// File: rtl/wrptr_level.sv
// Write-domain view of the read pointer: synchronize, Gray-decode, compute fill level,
// almost-full and sticky integrity flags, all registered on wclk.
module wrptr_level import wrptr_level_pkg::*; #(
  parameter int ADDRSIZE    = ADDRSIZE_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic         wclk,
  input  logic         wrst_n,
  wrptr_level_if.slave bus
);

  localparam int            PW       = ADDRSIZE + 1;
  localparam logic [PW-1:0] FULL_LVL = PW'(2 ** ADDRSIZE);

  logic [PW-1:0] wq2;
  logic [PW-1:0] prev_q;
  logic          prev_vld_q;
  logic [PW-1:0] wrbin_q;
  logic [PW-1:0] wlevel_q;
  logic          awfull_q;
  err_t          err_q;

  logic [PW-1:0] bin_nxt;
  logic [PW-1:0] lvl_nxt;
  logic          awfull_nxt;
  err_t          err_nxt;

  ptr_sync #(
    .WIDTH       (PW),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_rptr_sync (
    .clk   (wclk),
    .rst_n (wrst_n),
    .d     (bus.rptr),
    .q     (wq2)
  );

  always_comb begin
    // NOTE: every signal here gets a value on every path, so no latch is inferred.
    bin_nxt    = PW'(gray2bin(32'(wq2)));
    lvl_nxt    = bus.wbin - wrbin_q;
    awfull_nxt = (bus.awfull_thresh != '0) && (lvl_nxt >= bus.awfull_thresh);
    // Set terms are OR-ed after the clear so a coincident new error keeps the flag high.
    err_nxt.gray = (err_q.gray & ~bus.err_clr)
                 | (prev_vld_q && (popcount(32'(wq2 ^ prev_q)) > 1));
    err_nxt.ovf  = (err_q.ovf & ~bus.err_clr) | (lvl_nxt > FULL_LVL);
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
      wrbin_q    <= '0;
      wlevel_q   <= '0;
      awfull_q   <= 1'b0;
      err_q      <= '0;
    end else begin
      prev_q     <= wq2;
      prev_vld_q <= 1'b1;
      wrbin_q    <= bin_nxt;
      wlevel_q   <= lvl_nxt;
      awfull_q   <= awfull_nxt;
      err_q      <= err_nxt;
    end
  end

  assign bus.wq2_rptr = wq2;
  assign bus.wrbin    = wrbin_q;
  assign bus.wlevel   = wlevel_q;
  assign bus.awfull   = awfull_q;
  assign bus.gray_err = err_q.gray;
  assign bus.ovf_err  = err_q.ovf;

endmodule

// File: tb/tb_wrptr_level.sv
// Bench for wrptr_level: directed vector table, hand sequences for reset/error corners,
// and a random Gray walk checked against a sample-history reference model.
module tb_wrptr_level;

  localparam int S = 2;

  logic wclk = 1'b0;
  logic wrst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  wrptr_level_if #(.ADDRSIZE(4)) bus ();

  wrptr_level #(.ADDRSIZE(4), .SYNC_STAGES(S)) dut (
    .wclk   (wclk),
    .wrst_n (wrst_n),
    .bus    (bus)
  );

  always #5 wclk = ~wclk;

  // Reference model: history of rptr values seen at each edge since reset.
  logic [4:0]  rh[$];
  int unsigned since_rst;
  logic [4:0]  e_wq2, e_wrbin, e_wlevel;
  logic        e_awfull, m_gray, m_ovf;

  function automatic logic [4:0] tb_g2b(input logic [4:0] g);
    for (int b = 0; b < 32; b++) begin
      if (5'(b ^ (b >> 1)) == g) return 5'(b);
    end
    return '0;
  endfunction

  function automatic logic [4:0] tb_b2g(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    rh.delete();
    for (int i = 0; i < S + 2; i++) rh.push_back(5'd0);
    since_rst = 0;
    e_wq2 = '0; e_wrbin = '0; e_wlevel = '0; e_awfull = 1'b0;
    m_gray = 1'b0; m_ovf = 1'b0;
  endtask

  task automatic model_edge(input logic [4:0] r, w, t, input logic c);
    int         l;
    logic [4:0] lvl, cur, prv;
    rh.push_back(r);
    l        = rh.size();
    e_wq2    = rh[l-1-(S-1)];
    e_wrbin  = tb_g2b(rh[l-1-S]);
    lvl      = w - tb_g2b(rh[l-2-S]);
    cur      = rh[l-1-S];
    prv      = rh[l-2-S];
    e_wlevel = lvl;
    e_awfull = (t != 0) && (lvl >= t);
    m_ovf    = (m_ovf && !c) || (lvl > 5'd16);
    m_gray   = (m_gray && !c) || (since_rst >= 1 && $countones(cur ^ prv) > 1);
    since_rst++;
    if (rh.size() > 12) void'(rh.pop_front());
  endtask

  task automatic compare_model(input string tag);
    check({tag, ".wq2_rptr"}, bus.wq2_rptr, e_wq2);
    check({tag, ".wrbin"},    bus.wrbin,    e_wrbin);
    check({tag, ".wlevel"},   bus.wlevel,   e_wlevel);
    check({tag, ".awfull"},   5'(bus.awfull),   5'(e_awfull));
    check({tag, ".gray_err"}, 5'(bus.gray_err), 5'(m_gray));
    check({tag, ".ovf_err"},  5'(bus.ovf_err),  5'(m_ovf));
  endtask

  task automatic step(input logic [4:0] r, w, t, input logic c, input string tag);
    bus.rptr = r; bus.wbin = w; bus.awfull_thresh = t; bus.err_clr = c;
    @(posedge wclk);
    model_edge(r, w, t, c);
    #1;
    compare_model(tag);
  endtask

  task automatic apply_reset();
    wrst_n = 1'b0;
    #2;
    model_reset();
    compare_model("reset_async");
    repeat (2) @(posedge wclk);
    #1;
    compare_model("reset_held");
    wrst_n = 1'b1;
  endtask

  typedef struct {
    logic [4:0] r, w, t;
    logic       c;
    logic [4:0] q, b, l;
    logic       a;
  } vec_t;

  vec_t vecs[15];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [4:0] rb, w, t;
    logic       c;
    int         pick;

    bus.rptr = '0; bus.wbin = '0; bus.awfull_thresh = '0; bus.err_clr = 1'b0;
    wrst_n = 1'b1;
    #1;

    // Reset with active inputs; pointer appears after the sync latency.
    bus.rptr = 5'h1F; bus.wbin = 5'd9;
    apply_reset();
    step(5'h1F, 5'd9, 5'd0, 1'b0, "rst_rel1");
    check("rst_rel1_wq2_still_0", bus.wq2_rptr, 5'h00);
    step(5'h1F, 5'd9, 5'd0, 1'b0, "rst_rel2");
    check("rst_rel2_wq2", bus.wq2_rptr, 5'h1F);
    repeat (3) step(5'h1F, 5'd9, 5'd0, 1'b1, "rst_clr");

    // Latency and full/awfull vectors from a clean reset.
    vecs = '{
      '{5'd0,  5'd5, 5'd0,  1'b0, 5'd0,  5'd0,  5'd5,  1'b0},
      '{5'd1,  5'd5, 5'd0,  1'b0, 5'd0,  5'd0,  5'd5,  1'b0},
      '{5'd3,  5'd5, 5'd0,  1'b0, 5'd1,  5'd0,  5'd5,  1'b0},
      '{5'd2,  5'd5, 5'd0,  1'b0, 5'd3,  5'd1,  5'd5,  1'b0},
      '{5'd2,  5'd5, 5'd0,  1'b0, 5'd2,  5'd2,  5'd4,  1'b0},
      '{5'd2,  5'd5, 5'd0,  1'b0, 5'd2,  5'd3,  5'd3,  1'b0},
      '{5'd2,  5'd5, 5'd0,  1'b0, 5'd2,  5'd3,  5'd2,  1'b0},
      '{5'd26, 5'd3, 5'd14, 1'b0, 5'd2,  5'd3,  5'd0,  1'b0},
      '{5'd26, 5'd3, 5'd14, 1'b0, 5'd26, 5'd3,  5'd0,  1'b0},
      '{5'd26, 5'd3, 5'd14, 1'b0, 5'd26, 5'd19, 5'd0,  1'b0},
      '{5'd26, 5'd3, 5'd14, 1'b0, 5'd26, 5'd19, 5'd16, 1'b1},
      '{5'd17, 5'd2, 5'd14, 1'b0, 5'd26, 5'd19, 5'd15, 1'b1},
      '{5'd17, 5'd2, 5'd14, 1'b0, 5'd17, 5'd19, 5'd15, 1'b1},
      '{5'd17, 5'd2, 5'd14, 1'b0, 5'd17, 5'd30, 5'd15, 1'b1},
      '{5'd17, 5'd2, 5'd14, 1'b0, 5'd17, 5'd30, 5'd4,  1'b0}
    };
    apply_reset();
    for (int i = 0; i < 15; i++) begin
      step(vecs[i].r, vecs[i].w, vecs[i].t, vecs[i].c, $sformatf("vec%0d", i));
      check($sformatf("vec%0d_wq2", i),    bus.wq2_rptr, vecs[i].q);
      check($sformatf("vec%0d_wrbin", i),  bus.wrbin,    vecs[i].b);
      check($sformatf("vec%0d_wlevel", i), bus.wlevel,   vecs[i].l);
      check($sformatf("vec%0d_awfull", i), 5'(bus.awfull), 5'(vecs[i].a));
      if (i == 10) check("full16_no_ovf", 5'(bus.ovf_err), 5'd0);
    end

    // Illegal Gray step, stickiness, and clear colliding with a new error.
    apply_reset();
    repeat (3) step(5'h00, 5'd2, 5'd0, 1'b0, "gray_pre");
    step(5'h03, 5'd2, 5'd0, 1'b0, "gray_e1");
    check("gray_e1", 5'(bus.gray_err), 5'd0);
    step(5'h03, 5'd2, 5'd0, 1'b0, "gray_e2");
    check("gray_e2", 5'(bus.gray_err), 5'd0);
    step(5'h03, 5'd2, 5'd0, 1'b0, "gray_e3");
    check("gray_e3_set", 5'(bus.gray_err), 5'd1);
    repeat (4) step(5'h03, 5'd2, 5'd0, 1'b0, "gray_hold");
    check("gray_sticky", 5'(bus.gray_err), 5'd1);
    step(5'h1C, 5'd2, 5'd0, 1'b0, "gray_j1");
    step(5'h1C, 5'd2, 5'd0, 1'b0, "gray_j2");
    step(5'h1C, 5'd2, 5'd0, 1'b1, "gray_clr_vs_set");
    check("gray_set_wins", 5'(bus.gray_err), 5'd1);
    step(5'h1C, 5'd2, 5'd0, 1'b1, "gray_clr");
    check("gray_cleared", 5'(bus.gray_err), 5'd0);

    // Overflow and clear; then awfull disable at level 16.
    apply_reset();
    step(5'd0, 5'd20, 5'd0, 1'b0, "ovf_set");
    check("ovf_level20", bus.wlevel, 5'd20);
    check("ovf_set", 5'(bus.ovf_err), 5'd1);
    step(5'd0, 5'd8, 5'd0, 1'b0, "ovf_hold");
    check("ovf_sticky", 5'(bus.ovf_err), 5'd1);
    step(5'd0, 5'd8, 5'd0, 1'b1, "ovf_clr");
    check("ovf_cleared", 5'(bus.ovf_err), 5'd0);
    step(5'd0, 5'd16, 5'd14, 1'b0, "awf_on");
    check("awf_on", 5'(bus.awfull), 5'd1);
    step(5'd0, 5'd16, 5'd0, 1'b0, "awf_dis");
    check("awf_disabled", 5'(bus.awfull), 5'd0);

    // Mid-stream asynchronous reset.
    repeat (4) step(tb_b2g(5'd5), 5'd30, 5'd14, 1'b0, "mid_pre");
    wrst_n = 1'b0;
    #2;
    model_reset();
    compare_model("mid_rst");
    check("mid_rst_wq2", bus.wq2_rptr, 5'd0);
    @(posedge wclk);
    #1;
    wrst_n = 1'b1;

    // Random Gray walk with occasional illegal jumps against the model.
    rb = '0; t = 5'd12;
    for (int i = 0; i < 400; i++) begin
      pick = $urandom_range(0, 15);
      if (pick == 0)      rb = 5'($urandom);
      else if (pick < 10) rb = rb + 5'd1;
      if (i % 50 == 0)    t = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 20));
      w = rb + 5'($urandom_range(0, 20));
      c = ($urandom_range(0, 7) == 0);
      step(tb_b2g(rb), w, t, c, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
